// File: rtl/data_mem_access_pkg.sv
// Shared encodings and constants for the data-memory access stage.
package data_mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dma_state_e;

  // Read data returned when an access is abandoned on timeout.
  localparam logic [15:0] MEM_ERR_DATA = 16'hFFFF;

  // Working-register select in the register bank, for the decoder.
  localparam logic [5:0]  SEL_W        = 6'd34;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Ack-wait counter; tc_o flags the TIMEOUT-th consecutive enabled cycle.
module dmem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic nreset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!nreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = en_i & (cnt_q == TC_VAL);

endmodule

// File: rtl/data_mem_access.sv
// Converts decoder MR/MW levels into an ack handshake with the data RAM,
// returning read data to the register bank via a one-cycle MR strobe.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] W_IN,
  output logic [DATA_W-1:0] W_MEM_IN,
  output logic              MR_bank,
  output logic              stall,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  dma_state_e        state_q;
  logic              mem_req_q, mem_we_q, mr_bank_q, mem_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, w_mem_q;
  logic              cnt_en, cnt_clr, cnt_tc;

  assign cnt_en  = (state_q == ACCESS) & ~mem_ack;
  assign cnt_clr = (state_q != ACCESS);

  dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .nreset (nreset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      w_mem_q     <= '0;
      mr_bank_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      mr_bank_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MR ^ MW) begin
            mem_addr_q  <= Addr;
            mem_wdata_q <= W_IN;
            mem_we_q    <= MW;
            mem_req_q   <= 1'b1;
            state_q     <= ACCESS;
          end else if (MR & MW) begin
            mem_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (!mem_we_q) begin
              w_mem_q   <= mem_rdata;
              mr_bank_q <= 1'b1;
            end
          end else if (cnt_tc) begin
            mem_req_q <= 1'b0;
            mem_err_q <= 1'b1;
            state_q   <= DONE;
            if (!mem_we_q) begin
              w_mem_q   <= DATA_W'(MEM_ERR_DATA);
              mr_bank_q <= 1'b1;
            end
          end
        end
        // Requests still held here belong to the retiring instruction.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Low in DONE so the bank write-enable captures W_MEM_IN at its end.
  assign stall = (state_q == ACCESS) | ((state_q == IDLE) & (MR ^ MW));

  assign W_MEM_IN  = w_mem_q;
  assign MR_bank   = mr_bank_q;
  assign mem_err   = mem_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: per-cycle vector table plus
// hand-written back-to-back, reset-abort and timeout sequences.
module tb_data_mem_access;

  logic        clk = 1'b0;
  logic        nreset;
  logic        MR, MW, MR_bank, stall, mem_err, mem_req, mem_we, mem_ack;
  logic [15:0] Addr, W_IN, W_MEM_IN, mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_access #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .MR        (MR),
    .MW        (MW),
    .Addr      (Addr),
    .W_IN      (W_IN),
    .W_MEM_IN  (W_MEM_IN),
    .MR_bank   (MR_bank),
    .stall     (stall),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic        mr, mw;
    logic [15:0] addr, win, rdata;
    logic        ack;
    logic        req, we;
    logic [15:0] maddr, wdata;
    logic        stall, mrb;
    logic [15:0] wmem;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic mr, logic mw, logic [15:0] addr, logic [15:0] win,
                             logic [15:0] rdata, logic ack, logic req, logic we,
                             logic [15:0] maddr, logic [15:0] wdata, logic stl,
                             logic mrb, logic [15:0] wmem, logic err);
    vec_t r;
    r.mr = mr; r.mw = mw; r.addr = addr; r.win = win; r.rdata = rdata; r.ack = ack;
    r.req = req; r.we = we; r.maddr = maddr; r.wdata = wdata; r.stall = stl;
    r.mrb = mrb; r.wmem = wmem; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [15:0] a,
                       input logic [15:0] w, input logic [15:0] rd, input logic ack);
    MR = mr; MW = mw; Addr = a; W_IN = w; mem_rdata = rd; mem_ack = ack;
  endtask

  initial begin
    int n;
    nreset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Reset state
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst W_MEM_IN", W_MEM_IN, 0);
    chk("rst MR_bank", MR_bank, 0);
    chk("rst mem_err", mem_err, 0);
    chk("rst stall", stall, 0);
    nreset = 1'b1;

    // Read with ack on the first ACCESS cycle
    vecs.push_back(v(1,0,16'h0040,0,0,0,           0,0,16'h0000,0,1,0,16'h0000,0));
    vecs.push_back(v(1,0,16'h0040,0,16'hBEEF,1,    1,0,16'h0040,0,1,0,16'h0000,0));
    vecs.push_back(v(0,0,0,0,0,0,                  0,0,16'h0040,0,0,1,16'hBEEF,0));
    vecs.push_back(v(0,0,0,0,0,0,                  0,0,16'h0040,0,0,0,16'hBEEF,0));
    // Write, ack on the fourth ACCESS cycle; read data on ack must be ignored
    vecs.push_back(v(0,1,16'h0010,16'h1234,0,0,       0,0,16'h0040,0,1,0,16'hBEEF,0));
    vecs.push_back(v(0,1,16'h0010,16'h1234,16'h5555,0, 1,1,16'h0010,16'h1234,1,0,16'hBEEF,0));
    vecs.push_back(v(0,1,16'h0010,16'h1234,16'h5555,0, 1,1,16'h0010,16'h1234,1,0,16'hBEEF,0));
    vecs.push_back(v(0,1,16'h0010,16'h1234,16'h5555,0, 1,1,16'h0010,16'h1234,1,0,16'hBEEF,0));
    vecs.push_back(v(0,1,16'h0010,16'h1234,16'h5555,1, 1,1,16'h0010,16'h1234,1,0,16'hBEEF,0));
    vecs.push_back(v(0,0,0,0,0,0,                     0,1,16'h0010,16'h1234,0,0,16'hBEEF,0));
    // Stray ack while idle
    vecs.push_back(v(0,0,0,0,16'h7777,1,              0,1,16'h0010,16'h1234,0,0,16'hBEEF,0));
    vecs.push_back(v(0,0,0,0,0,0,                     0,1,16'h0010,16'h1234,0,0,16'hBEEF,0));
    // Illegal MR & MW
    vecs.push_back(v(1,1,16'h0099,16'h4321,0,0,       0,1,16'h0010,16'h1234,0,0,16'hBEEF,0));
    vecs.push_back(v(0,0,0,0,0,0,                     0,1,16'h0010,16'h1234,0,0,16'hBEEF,1));
    vecs.push_back(v(0,0,0,0,0,0,                     0,1,16'h0010,16'h1234,0,0,16'hBEEF,1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].mr, vecs[i].mw, vecs[i].addr, vecs[i].win, vecs[i].rdata, vecs[i].ack);
      #1;
      chk($sformatf("v%0d mem_req", i),   mem_req,   vecs[i].req);
      chk($sformatf("v%0d mem_we", i),    mem_we,    vecs[i].we);
      chk($sformatf("v%0d mem_addr", i),  mem_addr,  vecs[i].maddr);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].wdata);
      chk($sformatf("v%0d stall", i),     stall,     vecs[i].stall);
      chk($sformatf("v%0d MR_bank", i),   MR_bank,   vecs[i].mrb);
      chk($sformatf("v%0d W_MEM_IN", i),  W_MEM_IN,  vecs[i].wmem);
      chk($sformatf("v%0d mem_err", i),   mem_err,   vecs[i].err);
      tick();
    end

    // Back-to-back reads with MR held through DONE
    drive(1, 0, 16'h0001, 0, 0, 0);
    tick();
    chk("b2b c1 mem_req", mem_req, 1);
    chk("b2b c1 mem_addr", mem_addr, 16'h0001);
    drive(1, 0, 16'h0001, 0, 16'h1111, 1);
    tick();
    drive(1, 0, 16'h0002, 0, 0, 0);
    #1;
    chk("b2b done1 MR_bank", MR_bank, 1);
    chk("b2b done1 W_MEM_IN", W_MEM_IN, 16'h1111);
    chk("b2b done1 stall", stall, 0);
    tick();
    chk("b2b idle no dup req", mem_req, 0);
    chk("b2b idle stall", stall, 1);
    chk("b2b idle MR_bank", MR_bank, 0);
    tick();
    chk("b2b c4 mem_req", mem_req, 1);
    chk("b2b c4 mem_addr", mem_addr, 16'h0002);
    drive(1, 0, 16'h0002, 0, 16'h2222, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("b2b done2 MR_bank", MR_bank, 1);
    chk("b2b done2 W_MEM_IN", W_MEM_IN, 16'h2222);
    tick();
    chk("b2b after mem_req", mem_req, 0);

    // Reset in the middle of an access; late ack must be ignored
    drive(1, 0, 16'h0055, 0, 0, 0);
    tick();
    chk("rstmid mem_req before", mem_req, 1);
    nreset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("rstmid mem_req", mem_req, 0);
    chk("rstmid W_MEM_IN", W_MEM_IN, 0);
    chk("rstmid mem_err", mem_err, 0);
    chk("rstmid stall", stall, 0);
    nreset = 1'b1;
    drive(0, 0, 0, 0, 16'hAAAA, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid late ack mem_req", mem_req, 0);
    chk("rstmid late ack MR_bank", MR_bank, 0);
    chk("rstmid late ack W_MEM_IN", W_MEM_IN, 0);
    chk("rstmid late ack stall", stall, 0);

    // Timeout on a read, TIMEOUT=4
    drive(1, 0, 16'h0077, 0, 0, 0);
    tick();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    chk("tmo req cycles", n, 4);
    chk("tmo MR_bank", MR_bank, 1);
    chk("tmo W_MEM_IN", W_MEM_IN, 16'hFFFF);
    chk("tmo mem_err", mem_err, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("tmo err sticky", mem_err, 1);
    chk("tmo MR_bank drop", MR_bank, 0);
    nreset = 1'b0;
    tick();
    chk("final rst mem_err", mem_err, 0);
    nreset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
